// File: rtl/gain_ramp_sequencer_if.sv
// rtl/gain_ramp_sequencer_if.sv - host/DAC-writer signal bundle for the gain ramp sequencer
// master: drives ramp requests and downstream spi_ready, observes DAC writer outputs and status
// slave : the sequencer itself (consumes requests, produces dds_gain/strobe/status)
interface gain_ramp_sequencer_if;
  logic [15:0] target_gain;
  logic        target_update;
  logic [15:0] step_size;
  logic [15:0] step_interval;
  logic [15:0] gain_limit;
  logic        abort;
  logic        spi_ready;
  logic [15:0] dds_gain;
  logic        dds_gain_update;
  logic [15:0] current_gain;
  logic        ramp_busy;
  logic        ramp_done;
  logic        ramp_error;

  modport master (
    output target_gain, target_update, step_size, step_interval, gain_limit, abort, spi_ready,
    input  dds_gain, dds_gain_update, current_gain, ramp_busy, ramp_done, ramp_error
  );

  modport slave (
    input  target_gain, target_update, step_size, step_interval, gain_limit, abort, spi_ready,
    output dds_gain, dds_gain_update, current_gain, ramp_busy, ramp_done, ramp_error
  );
endinterface

// File: rtl/gain_ramp_sequencer.sv
// rtl/gain_ramp_sequencer.sv - steps a DAC gain code toward a target in bounded, settled increments
// clk/rst : rising-edge clock, synchronous active-high reset
// bus     : slave side of gain_ramp_sequencer_if (requests, spi_ready in; dds_gain/strobe/status out)
module gain_ramp_sequencer #(
  parameter logic [15:0] GAIN_INIT     = 16'h6050,
  parameter int          SETTLE_CYCLES = 24,
  parameter int          BUSY_TIMEOUT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gain_ramp_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CALC, ISSUE, WAIT_BUSY, WAIT_READY, SETTLE, INTERVAL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] current_q, current_d;
  logic [15:0] dds_gain_q, dds_gain_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        abort_q, abort_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic        strobe;

  logic        upd_valid;
  logic        new_pending;
  logic        abort_now;
  logic [15:0] clamped_target;
  logic [15:0] step_eff;
  logic [15:0] interval_eff;
  logic [15:0] next_code;
  logic        settle_last;
  logic        interval_last;
  logic        busy_expired;

  assign upd_valid      = bus.target_update && (bus.gain_limit != 16'd0);
  // An abort in the same cycle still latches the target but must not arm a new ramp.
  assign new_pending    = upd_valid && !bus.abort;
  assign abort_now      = abort_q || bus.abort;
  assign clamped_target = (bus.target_gain < bus.gain_limit) ? bus.target_gain
                                                             : bus.gain_limit - 16'd1;
  assign step_eff       = (bus.step_size == 16'd0) ? 16'd1 : bus.step_size;
  assign interval_eff   = (bus.step_interval == 16'd0) ? 16'd1 : bus.step_interval;

  // Compare remaining distance against the step first so the sum/difference can neither
  // overshoot the target nor wrap around 16 bits.
  always_comb begin
    next_code = target_q;
    if (target_q > current_q) begin
      if ((target_q - current_q) > step_eff) next_code = current_q + step_eff;
    end else begin
      if ((current_q - target_q) > step_eff) next_code = current_q - step_eff;
    end
  end

  assign settle_last   = (int'(cnt_q) + 1) >= SETTLE_CYCLES;
  assign interval_last = ({1'b0, cnt_q} + 17'd1) >= {1'b0, interval_eff};
  assign busy_expired  = (int'(cnt_q) + 1) >= BUSY_TIMEOUT;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    current_d  = current_q;
    dds_gain_d = dds_gain_q;
    pending_d  = pending_q;
    abort_d    = abort_q;
    error_d    = error_q;
    done_d     = 1'b0;
    strobe     = 1'b0;
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    if (bus.target_update) begin
      if (bus.gain_limit == 16'd0) begin
        error_d = 1'b1;
      end else begin
        target_d = clamped_target;
        if (!bus.abort) pending_d = 1'b1;
      end
    end
    if (bus.abort && (state_q != IDLE)) abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        // A fresh request skips the pending round-trip so the strobe lands two clocks later.
        if ((pending_q || new_pending) && bus.spi_ready) state_d = CALC;
      end
      CALC: begin
        if (abort_now) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          abort_d   = 1'b0;
        end else begin
          if (!new_pending) pending_d = 1'b0;
          if (target_q == current_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dds_gain_d = next_code;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.spi_ready) begin
          strobe  = 1'b1;
          state_d = WAIT_BUSY;
        end else if (abort_now) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          abort_d   = 1'b0;
        end
      end
      WAIT_BUSY: begin
        if (!bus.spi_ready) begin
          state_d = WAIT_READY;
        end else if (busy_expired) begin
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_READY: begin
        if (bus.spi_ready) begin
          current_d = dds_gain_q;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_last) begin
          if (abort_now) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            abort_d   = 1'b0;
          end else if (current_q == target_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (!new_pending) pending_d = 1'b0;
          end else begin
            state_d = INTERVAL;
          end
        end
      end
      INTERVAL: begin
        if (abort_now) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          abort_d   = 1'b0;
        end else if (interval_last) begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state's counter starts from zero on entry.
    if (state_d != state_q) cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= GAIN_INIT;
      current_q  <= GAIN_INIT;
      dds_gain_q <= GAIN_INIT;
      cnt_q      <= 16'd0;
      pending_q  <= 1'b0;
      abort_q    <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      current_q  <= current_d;
      dds_gain_q <= dds_gain_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      abort_q    <= abort_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign bus.dds_gain        = dds_gain_q;
  assign bus.dds_gain_update = strobe;
  assign bus.current_gain    = current_q;
  assign bus.ramp_busy       = (state_q != IDLE);
  assign bus.ramp_done       = done_q;
  assign bus.ramp_error      = error_q;

endmodule

// File: tb/tb_gain_ramp_sequencer.sv
// tb/tb_gain_ramp_sequencer.sv - randomized self-checking bench for gain_ramp_sequencer
module tb_gain_ramp_sequencer;
  logic clk;
  logic rst;
  gain_ramp_sequencer_if bus ();

  gain_ramp_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int n_strobe, n_done, first_cyc, last_cyc, min_gap, err_cyc, upd_cyc;
  bit err_seen;
  bit drop_next, stuck;
  int low_len, low_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    n_strobe = 0;
    n_done = 0;
    first_cyc = 0;
    last_cyc = 0;
    min_gap = 32'h7fffffff;
    err_seen = 1'b0;
    err_cyc = 0;
  endtask

  // One clock: sample outputs after the edge, then step the downstream DAC writer model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.dds_gain_update) begin
      chk("strobe_while_ready", bus.spi_ready, 1);
      if (n_strobe == 0) first_cyc = cyc;
      else if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
      last_cyc = cyc;
      got_q.push_back(bus.dds_gain);
      n_strobe++;
    end
    if (bus.ramp_done) n_done++;
    if (bus.ramp_error && !err_seen) begin
      err_seen = 1'b1;
      err_cyc = cyc;
    end
    if (drop_next) begin
      bus.spi_ready = 1'b0;
      low_left = low_len;
      drop_next = 1'b0;
    end else if (!bus.spi_ready && low_left > 0) begin
      low_left--;
      if (low_left == 0) bus.spi_ready = 1'b1;
    end
    if (bus.dds_gain_update && !stuck) drop_next = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.target_update = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus.spi_ready = 1'b1;
    drop_next = 1'b0;
    low_left = 0;
    stuck = 1'b0;
    tick();
    clear_obs();
  endtask

  // Expected code sequence from the ramp rules: step toward the target, never past it.
  task automatic model_ramp(input int from, input int to, input int st);
    int c;
    int s;
    c = from;
    s = (st == 0) ? 1 : st;
    while (c != to) begin
      if (to > c) c = (to - c <= s) ? to : c + s;
      else        c = (c - to <= s) ? to : c - s;
      exp_q.push_back(c[15:0]);
    end
  endtask

  task automatic cmp_codes(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_code%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic run_ramp(input logic [15:0] tgt, input logic [15:0] st, input logic [15:0] iv,
                          input logic [15:0] lim, input int low, input int mid_at,
                          input logic [15:0] mid_tgt, input bit mid_upd, input bit mid_abort);
    bit mid_done;
    mid_done = 1'b0;
    bus.step_size = st;
    bus.step_interval = iv;
    bus.gain_limit = lim;
    low_len = low;
    bus.target_gain = tgt;
    bus.target_update = 1'b1;
    upd_cyc = cyc;
    tick();
    bus.target_update = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (mid_at > 0 && !mid_done && n_strobe >= mid_at) begin
        mid_done = 1'b1;
        bus.target_gain = mid_tgt;
        bus.target_update = mid_upd;
        bus.abort = mid_abort;
        tick();
        bus.target_update = 1'b0;
        bus.abort = 1'b0;
      end else begin
        tick();
      end
      if (!bus.ramp_busy) break;
    end
    chk("ramp_finished", bus.ramp_busy, 0);
  endtask

  initial begin
    int cur, st, se, span, tgt, lim, eff;
    bit up;
    bus.target_gain = 16'h0;
    bus.target_update = 1'b0;
    bus.step_size = 16'd1;
    bus.step_interval = 16'd1;
    bus.gain_limit = 16'hFFFF;
    bus.abort = 1'b0;
    bus.spi_ready = 1'b1;
    drop_next = 1'b0;
    stuck = 1'b0;
    low_len = 1;
    low_left = 0;
    rst = 1'b0;

    // Reset values
    do_reset();
    chk("rst_dds_gain", bus.dds_gain, 16'h6050);
    chk("rst_current", bus.current_gain, 16'h6050);
    chk("rst_update", bus.dds_gain_update, 0);
    chk("rst_busy", bus.ramp_busy, 0);
    chk("rst_done", bus.ramp_done, 0);
    chk("rst_error", bus.ramp_error, 0);

    // Slow downstream, four up-steps
    run_ramp(16'h6060, 16'd4, 16'd10, 16'hFFFF, 50, 0, 16'h0, 0, 0);
    model_ramp(16'h6050, 16'h6060, 4);
    cmp_codes("up4");
    chk("up4_latency", first_cyc - upd_cyc, 2);
    chk("up4_done", n_done, 1);
    chk("up4_gap_ok", min_gap >= 84, 1);
    chk("up4_current", bus.current_gain, 16'h6060);

    // Down ramp clamped at target
    do_reset();
    run_ramp(16'h6000, 16'h0030, 16'd3, 16'hFFFF, 4, 0, 16'h0, 0, 0);
    model_ramp(16'h6050, 16'h6000, 16'h30);
    cmp_codes("down");
    chk("down_done", n_done, 1);

    // Target above limit is clamped to limit-1
    do_reset();
    run_ramp(16'h7000, 16'd4, 16'd2, 16'h6055, 3, 0, 16'h0, 0, 0);
    model_ramp(16'h6050, 16'h6054, 4);
    cmp_codes("limit");
    chk("limit_current", bus.current_gain, 16'h6054);

    // Zero limit: request dropped, error flagged
    clear_obs();
    run_ramp(16'h6100, 16'd4, 16'd2, 16'h0000, 3, 0, 16'h0, 0, 0);
    for (int k = 0; k < 10; k++) tick();
    chk("lim0_strobes", n_strobe, 0);
    chk("lim0_error", bus.ramp_error, 1);

    // Downstream never goes busy: timeout
    do_reset();
    stuck = 1'b1;
    run_ramp(16'h6060, 16'd4, 16'd2, 16'hFFFF, 3, 0, 16'h0, 0, 0);
    chk("tmo_strobes", n_strobe, 1);
    chk("tmo_error", bus.ramp_error, 1);
    chk("tmo_err_delay", err_cyc - first_cyc, 9);
    chk("tmo_current", bus.current_gain, 16'h6050);
    chk("tmo_done", n_done, 0);
    stuck = 1'b0;

    // Retarget mid-ramp
    do_reset();
    run_ramp(16'h6080, 16'd8, 16'd5, 16'hFFFF, 5, 2, 16'h6058, 1, 0);
    exp_q.push_back(16'h6058);
    exp_q.push_back(16'h6060);
    model_ramp(16'h6060, 16'h6058, 8);
    cmp_codes("retgt");
    chk("retgt_done", n_done, 1);
    chk("retgt_current", bus.current_gain, 16'h6058);

    // Abort together with a new target
    do_reset();
    run_ramp(16'h6080, 16'd8, 16'd5, 16'hFFFF, 5, 1, 16'h6070, 1, 1);
    for (int k = 0; k < 50; k++) tick();
    exp_q.push_back(16'h6058);
    cmp_codes("abort");
    chk("abort_done", n_done, 0);
    chk("abort_current", bus.current_gain, 16'h6058);
    chk("abort_idle", bus.ramp_busy, 0);

    // Randomized ramps chained from the previous final code
    do_reset();
    cur = 16'h6050;
    for (int it = 0; it < 8; it++) begin
      clear_obs();
      st = $urandom_range(0, 512);
      se = (st == 0) ? 1 : st;
      span = se * $urandom_range(0, 6);
      up = $urandom_range(0, 1);
      tgt = up ? cur + span : cur - span;
      if (tgt > 65535) tgt = 65535;
      if (tgt < 0) tgt = 0;
      lim = 65535;
      if ($urandom_range(0, 2) == 0 && cur < 65535) lim = $urandom_range(cur + 1, 65535);
      eff = (tgt < lim) ? tgt : lim - 1;
      run_ramp(tgt[15:0], st[15:0], 16'($urandom_range(0, 8)), lim[15:0],
               $urandom_range(1, 8), 0, 16'h0, 0, 0);
      model_ramp(cur, eff, st);
      cmp_codes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_done", it), n_done, 1);
      chk($sformatf("rnd%0d_current", it), bus.current_gain, eff[15:0]);
      cur = eff;
    end
    chk("rnd_error", bus.ramp_error, 0);

    // Reset while waiting for the DAC writer to finish
    do_reset();
    bus.step_size = 16'd8;
    bus.step_interval = 16'd2;
    bus.gain_limit = 16'hFFFF;
    low_len = 20;
    bus.target_gain = 16'h6080;
    bus.target_update = 1'b1;
    tick();
    bus.target_update = 1'b0;
    for (int k = 0; k < 200 && n_strobe == 0; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_dds_gain", bus.dds_gain, 16'h6050);
    chk("rstmid_current", bus.current_gain, 16'h6050);
    chk("rstmid_update", bus.dds_gain_update, 0);
    chk("rstmid_busy", bus.ramp_busy, 0);
    chk("rstmid_done", bus.ramp_done, 0);
    chk("rstmid_error", bus.ramp_error, 0);
    rst = 1'b0;
    n_strobe = 0;
    for (int k = 0; k < 100; k++) tick();
    chk("rstmid_no_strobe", n_strobe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/gain_ramp_sequencer.md
GAIN_RAMP_SEQUENCER -- requirements
Module: gain_ramp_sequencer

Interface
REQ-001 SHALL have parameter GAIN_INIT, default 16'h6050, the gain value assumed present at the DAC after reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 24, the clocks waited after spi_ready rises before the next step is allowed.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 8, the clocks allowed for spi_ready to fall after an issued update.
REQ-004 SHALL have ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
target_gain  in  16  requested final gain code
target_update  in  1  1-cycle pulse, latches target_gain
step_size  in  16  max code change per step; 0 treated as 1
step_interval  in  16  idle clocks between steps; 0 treated as 1
gain_limit  in  16  downstream current limit; issued codes SHALL be < gain_limit
abort  in  1  1-cycle pulse, stop ramp after in-flight transfer
spi_ready  in  1  downstream DAC writer ready (high = idle)
dds_gain  out  16  gain code to DAC writer
dds_gain_update  out  1  1-cycle strobe, dds_gain valid
current_gain  out  16  last code issued and acknowledged
ramp_busy  out  1  high in any state other than IDLE
ramp_done  out  1  1-cycle pulse when current_gain reaches target
ramp_error  out  1  sticky; timeout or invalid limit

Function
REQ-005 SHALL implement states IDLE, CALC, ISSUE, WAIT_BUSY, WAIT_READY, SETTLE, INTERVAL.
REQ-006 target_update SHALL latch min(target_gain, gain_limit-1) into target register; if gain_limit==0 the update SHALL be ignored and ramp_error set.
REQ-007 IDLE -> CALC on the cycle after a latched pending target, only when spi_ready is high; otherwise remain IDLE with pending held.
REQ-008 CALC: if target==current_gain -> pulse ramp_done, go IDLE, no strobe; else next = current +/- step, clamped to target (no overshoot, no 16-bit wrap), go ISSUE.
REQ-009 With IDLE and spi_ready high, dds_gain_update SHALL assert exactly 2 clocks after target_update, dds_gain stable from that cycle until the next strobe.
REQ-010 ISSUE: strobe one cycle, go WAIT_BUSY; WAIT_BUSY -> WAIT_READY when spi_ready low; if BUSY_TIMEOUT clocks elapse first, set ramp_error, go IDLE, current_gain unchanged.
REQ-011 WAIT_READY -> SETTLE on spi_ready high; current_gain SHALL update to dds_gain on that transition.
REQ-012 SETTLE counts SETTLE_CYCLES clocks, then: if current_gain==target -> ramp_done pulse, IDLE; else INTERVAL.
REQ-013 INTERVAL counts step_interval (min 1) clocks, then CALC.
REQ-014 target_update mid-ramp SHALL overwrite target (with REQ-006 clamp); takes effect at next CALC; in-flight transfer not disturbed; no ramp_done for superseded target.
REQ-015 abort SHALL be remembered; taken at exit of SETTLE or in INTERVAL/CALC -> IDLE, no ramp_done, pending target cleared; abort in IDLE ignored.
REQ-016 Simultaneous abort and target_update: abort wins, target still latched but not pending.
REQ-017 Counters SHALL be 16 bits minimum and saturate, never wrap.
REQ-018 At most one strobe per downstream transaction; no strobe while spi_ready low.

Reset
REQ-019 rst SHALL set: dds_gain=current_gain=target=GAIN_INIT, dds_gain_update=0, ramp_busy=0, ramp_done=0, ramp_error=0, state IDLE, pending/abort flags clear.
REQ-020 rst mid-ramp SHALL take effect the next clock regardless of spi_ready; no further strobe until new target_update.
REQ-021 ramp_error SHALL clear only on rst.

Verification
REQ-022 Reset, target 16'h6060, step 4, interval 10, limit FFFF, model downstream ready low 50 clocks -> 4 strobes, codes 6054,6058,605C,6060, one ramp_done, spacing >= 50+24+10.
REQ-023 target 16'h6000 from 6050, step 16'h30 -> codes 6020,6000 (clamped, no undershoot), ramp_done once.
REQ-024 gain_limit 16'h6055, target 16'h7000 -> final code 6054; gain_limit 0 -> no strobe, ramp_error=1.
REQ-025 spi_ready held high after strobe -> after 8 clocks ramp_error=1, IDLE, current_gain unchanged.
REQ-026 Mid-ramp new target and abort-on-same-cycle cases: new target redirects at next CALC; abort stops after in-flight transfer, no ramp_done.
REQ-027 rst asserted while WAIT_READY -> all outputs at REQ-019 values next clock, no strobe afterwards.
